multicycle_sequencer: RTL and testbench

//  Multicycle control FSM for the RV32 core: sequences the shared ALU, regfile, PC and one unified memory port.

---
 rtl/riscv_ctrl_pkg.sv | 61 ++++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: opcodes, FSM states
// and the select/operation codes driven onto the datapath.
package riscv_ctrl_pkg;

    // Major opcodes (IR[6:0]) understood by the sequencer
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // ALU operation class
    localparam logic [1:0] ALU_IMM    = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_BRCMP  = 2'b11;

    // PC source select
    localparam logic [1:0] PC_PLUS4   = 2'd0;
    localparam logic [1:0] PC_TARGET  = 2'd1;
    localparam logic [1:0] PC_JALR    = 2'd2;

    // ALU operand A select
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;

    // Register write-back source select
    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;

    // True for every opcode the sequencer can execute; anything else traps
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_BRANCH,
            OPC_OPIMM, OPC_LUI, OPC_JALR, OPC_JAL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been left unanswered and flags the
// cycle in which the wait budget runs out.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // Wait counter: cleared by the sequencer, holds at the last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LAST)) begin
            r_count <= r_count + TW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Expiry only while still waiting; a same-cycle ready keeps i_inc low
    assign o_expire = i_inc && (r_count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the RV32 core. Steps each instruction through
// FETCH/DECODE/EXEC/[MEM]/[WB], drives datapath enables, handshakes with the
// unified memory port, traps on illegal opcodes or memory timeout and counts
// retired instructions.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             instr_done,
    output logic             trap_o,
    output logic [CNT_W-1:0] instret_o
);

    import riscv_ctrl_pkg::*;

    state_t           r_state;
    state_t           w_state_next;
    logic [6:0]       r_opcode;
    logic [CNT_W-1:0] r_instret;

    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_addr_sel;
    logic             w_ir_write;
    logic             w_pc_write;
    logic [1:0]       w_pc_src;
    logic [1:0]       w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_alu_op;
    logic             w_reg_write;
    logic [1:0]       w_wb_sel;
    logic             w_retire;
    logic             w_trap;

    logic             w_timer_clr;
    logic             w_timer_inc;
    logic             w_timer_expire;

    // Timer runs only in the memory states; any handshake restarts it
    assign w_timer_clr = ((r_state != ST_FETCH) && (r_state != ST_MEM)) || mem_ready;
    assign w_timer_inc = w_mem_req && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_timer_clr),
        .i_inc    (w_timer_inc),
        .o_expire (w_timer_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Opcode is captured at the end of DECODE and drives EXEC/MEM/WB decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opcode <= 7'd0;
        end else if (r_state == ST_DECODE) begin
            r_opcode <= opcode;
        end else begin
            r_opcode <= r_opcode;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end else begin
            r_instret <= r_instret;
        end
    end

    // Next-state and Moore output decode (FETCH strobes qualified by mem_ready)
    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_PLUS4;
        w_alu_src_a  = SRC_A_RS1;
        w_alu_src_b  = SRC_B_RS2;
        w_alu_op     = ALU_IMM;
        w_reg_write  = 1'b0;
        w_wb_sel     = WB_ALU;
        w_retire     = 1'b0;
        w_trap       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b0;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_pc_src     = PC_PLUS4;
                    w_state_next = ST_DECODE;
                end else if (w_timer_expire) begin
                    w_state_next = ST_TRAP;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // Branch/jump target precomputed into ALUOut
                w_alu_src_a = SRC_A_PC;
                w_alu_src_b = SRC_B_IMM;
                w_alu_op    = ALU_ADD;
                if (is_legal_opcode(opcode)) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_TRAP;
                end
            end

            ST_EXEC: begin
                case (r_opcode)
                    OPC_RTYPE: begin
                        w_alu_src_a  = SRC_A_RS1;
                        w_alu_src_b  = SRC_B_RS2;
                        w_alu_op     = ALU_RTYPE;
                        w_state_next = ST_WB;
                    end
                    OPC_OPIMM: begin
                        w_alu_src_a  = SRC_A_RS1;
                        w_alu_src_b  = SRC_B_IMM;
                        w_alu_op     = ALU_IMM;
                        w_state_next = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        w_alu_src_a  = SRC_A_RS1;
                        w_alu_src_b  = SRC_B_IMM;
                        w_alu_op     = ALU_ADD;
                        w_state_next = ST_MEM;
                    end
                    OPC_LUI: begin
                        w_alu_src_a  = SRC_A_ZERO;
                        w_alu_src_b  = SRC_B_IMM;
                        w_alu_op     = ALU_ADD;
                        w_state_next = ST_WB;
                    end
                    OPC_BRANCH: begin
                        w_alu_src_a  = SRC_A_RS1;
                        w_alu_src_b  = SRC_B_RS2;
                        w_alu_op     = ALU_BRCMP;
                        w_pc_write   = branch_taken;
                        w_pc_src     = PC_TARGET;
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    OPC_JAL: begin
                        w_pc_write   = 1'b1;
                        w_pc_src     = PC_TARGET;
                        w_state_next = ST_WB;
                    end
                    OPC_JALR: begin
                        w_alu_src_a  = SRC_A_RS1;
                        w_alu_src_b  = SRC_B_IMM;
                        w_alu_op     = ALU_ADD;
                        w_pc_write   = 1'b1;
                        w_pc_src     = PC_JALR;
                        w_state_next = ST_WB;
                    end
                    default: begin
                        // Unreachable: DECODE already filtered illegal opcodes
                        w_state_next = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_opcode == OPC_STORE);
                if (mem_ready) begin
                    if (r_opcode == OPC_STORE) begin
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_WB;
                    end
                end else if (w_timer_expire) begin
                    w_state_next = ST_TRAP;
                end else begin
                    w_state_next = ST_MEM;
                end
            end

            ST_WB: begin
                w_reg_write = 1'b1;
                case (r_opcode)
                    OPC_LOAD:          w_wb_sel = WB_MEM;
                    OPC_JAL, OPC_JALR: w_wb_sel = WB_PC4;
                    default:           w_wb_sel = WB_ALU;
                endcase
                w_retire     = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_TRAP: begin
                // Sticky: only reset leaves this state
                w_trap       = 1'b1;
                w_state_next = ST_TRAP;
            end

            default: begin
                w_state_next = ST_TRAP;
            end
        endcase
    end

    // Output stage: everything forced low while reset is asserted
    always_comb begin
        if (rst_n) begin
            mem_req    = w_mem_req;
            mem_we     = w_mem_we;
            addr_sel   = w_addr_sel;
            ir_write   = w_ir_write;
            pc_write   = w_pc_write;
            pc_src     = w_pc_src;
            alu_src_a  = w_alu_src_a;
            alu_src_b  = w_alu_src_b;
            alu_op     = w_alu_op;
            reg_write  = w_reg_write;
            wb_sel     = w_wb_sel;
            instr_done = w_retire;
            trap_o     = w_trap;
            instret_o  = r_instret;
        end else begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            reg_write  = 1'b0;
            wb_sel     = 2'd0;
            instr_done = 1'b0;
            trap_o     = 1'b0;
            instret_o  = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-instruction expectations are
// queued when an instruction is issued and checked when it retires.
module tb_multicycle_sequencer;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_JAL    = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic        reg_write, instr_done, trap_o;
    logic [31:0] instret_o;

    multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .instr_done(instr_done), .trap_o(trap_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        int         regw_cycle;
        logic [1:0] wb_sel;
        int         n_pcw;
        logic [1:0] last_pc_src;
        int         n_we;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_instret = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour derived from the latency/output table
    function automatic exp_t model(input logic [6:0] opc, input bit taken, input int fw, input int mw);
        exp_t e;
        bit   is_mem = (opc == T_LOAD) || (opc == T_STORE);
        bit   writes = (opc != T_BRANCH) && (opc != T_STORE);
        case (opc)
            T_BRANCH: e.cycles = 3;
            T_LOAD:   e.cycles = 5;
            default:  e.cycles = 4;
        endcase
        e.cycles     = e.cycles + fw + (is_mem ? mw : 0);
        e.regw_cycle = writes ? e.cycles : 0;
        if (opc == T_LOAD)                        e.wb_sel = 2'd1;
        else if (opc == T_JAL || opc == T_JALR)   e.wb_sel = 2'd2;
        else                                      e.wb_sel = 2'd0;
        e.n_pcw = 1;
        e.last_pc_src = 2'd0;
        if ((opc == T_BRANCH && taken) || opc == T_JAL) begin
            e.n_pcw = 2; e.last_pc_src = 2'd1;
        end else if (opc == T_JALR) begin
            e.n_pcw = 2; e.last_pc_src = 2'd2;
        end
        e.n_we = (opc == T_STORE) ? (mw + 1) : 0;
        return e;
    endfunction

    // Issue one instruction from FETCH; fw/mw = unanswered cycles before ready
    task automatic run_instr(input string name, input logic [6:0] opc, input bit taken,
                             input int fw, input int mw);
        int cyc = 0, wcnt = 0, req_idx = 0, cur_wait;
        int n_regw = 0, regw_cyc = 0, n_pcw = 0, n_we = 0, drops = 0;
        logic [1:0] wbs = 2'd0, lps = 2'd0;
        bit done = 1'b0, pending = 1'b0, hs, req;
        exp_t e;
        sb_q.push_back(model(opc, taken, fw, mw));
        opcode = opc;
        branch_taken = taken;
        while (!done && cyc < 200) begin
            cyc++;
            mem_ready = 1'b0;
            #1;
            cur_wait = (req_idx == 0) ? fw : mw;
            if (mem_req) mem_ready = (wcnt == cur_wait);
            #1;
            if (pending && !mem_req) drops++;
            if (reg_write) begin n_regw++; regw_cyc = cyc; wbs = wb_sel; end
            if (pc_write) begin n_pcw++; lps = pc_src; end
            if (mem_we) n_we++;
            if (instr_done) done = 1'b1;
            req = mem_req;
            hs = mem_req && mem_ready;
            pending = mem_req && !mem_ready;
            @(posedge clk);
            if (hs) begin req_idx++; wcnt = 0; end
            else if (req) wcnt++;
            #1;
        end
        mem_ready = 1'b0;
        chk({name, " retired"}, 32'(done), 32'd1);
        e = sb_q.pop_front();
        chk({name, " cycles"}, cyc, e.cycles);
        chk({name, " reg_write count"}, n_regw, (e.regw_cycle != 0) ? 1 : 0);
        chk({name, " reg_write cycle"}, regw_cyc, e.regw_cycle);
        chk({name, " wb_sel"}, 32'(wbs), 32'(e.wb_sel));
        chk({name, " pc_write count"}, n_pcw, e.n_pcw);
        chk({name, " last pc_src"}, 32'(lps), 32'(e.last_pc_src));
        chk({name, " mem_we cycles"}, n_we, e.n_we);
        chk({name, " mem_req drops"}, drops, 0);
        model_instret = model_instret + 32'd1;
        chk({name, " instret"}, instret_o, model_instret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst trap", 32'(trap_o), 32'd0);
        chk("rst instret", instret_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_instret = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit trap_ok;
        bit any_done;
        bit seen_we_ready;
        rst_n = 1'b0;
        opcode = 7'd0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        #1;
        chk("fetch mem_req", 32'(mem_req), 32'd1);
        chk("fetch addr_sel", 32'(addr_sel), 32'd0);

        run_instr("ADD",      T_RTYPE,  1'b0, 0, 0);
        run_instr("LW",       T_LOAD,   1'b0, 3, 3);
        run_instr("BEQ-T",    T_BRANCH, 1'b1, 0, 0);
        run_instr("BEQ-NT",   T_BRANCH, 1'b0, 0, 0);
        run_instr("SW",       T_STORE,  1'b0, 0, 2);
        run_instr("ADDI",     T_OPIMM,  1'b0, 1, 0);
        run_instr("LUI",      T_LUI,    1'b0, 0, 0);
        run_instr("JAL",      T_JAL,    1'b0, 0, 0);
        run_instr("JALR",     T_JALR,   1'b0, 2, 0);
        run_instr("ADD-RDY16",T_RTYPE,  1'b0, 15, 0);

        // Illegal opcode: trap after DECODE, sticky, instret frozen
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        #1;
        chk("ill fetch ir_write", 32'(ir_write), 32'd1);
        @(posedge clk); #1;
        chk("ill decode trap", 32'(trap_o), 32'd0);
        @(posedge clk); #1;
        chk("ill trap", 32'(trap_o), 32'd1);
        chk("ill mem_req", 32'(mem_req), 32'd0);
        trap_ok = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i % 2 == 0);
            #1;
            if (!trap_o || mem_req || pc_write || reg_write) trap_ok = 1'b0;
            if (instr_done) any_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("ill trap sticky", 32'(trap_ok), 32'd1);
        chk("ill no retire", 32'(any_done), 32'd0);
        chk("ill instret frozen", instret_o, model_instret);
        do_reset();
        #1;
        chk("ill cleared trap", 32'(trap_o), 32'd0);

        // Fetch timeout: 16 unanswered cycles then trap
        mem_ready = 1'b0;
        opcode = T_RTYPE;
        for (int i = 1; i <= 16; i++) begin
            #1;
            if (i == 16) begin
                chk("tmo cycle16 trap", 32'(trap_o), 32'd0);
                chk("tmo cycle16 mem_req", 32'(mem_req), 32'd1);
            end
            @(posedge clk); #1;
        end
        chk("tmo trap", 32'(trap_o), 32'd1);
        chk("tmo mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("tmo sticky", 32'(trap_o), 32'd1);
        chk("tmo instret", instret_o, 32'd0);
        do_reset();

        // Store interrupted by reset while in MEM
        run_instr("ADD-pre", T_RTYPE, 1'b0, 0, 0);
        opcode = T_STORE;
        mem_ready = 1'b1;
        seen_we_ready = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("swr mem addr_sel", 32'(addr_sel), 32'd1);
        chk("swr mem_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        if (mem_we && mem_ready) seen_we_ready = 1'b1;
        chk("swr rst mem_we", 32'(mem_we), 32'd0);
        chk("swr rst pc_write", 32'(pc_write | reg_write), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_instret = 32'd0;
        #1;
        chk("swr no we+ready", 32'(seen_we_ready), 32'd0);
        chk("swr fetch mem_req", 32'(mem_req), 32'd1);
        chk("swr fetch addr_sel", 32'(addr_sel), 32'd0);
        chk("swr instret", instret_o, 32'd0);
        run_instr("ADD-post", T_RTYPE, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
